// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ARM-subset pipeline: instruction modes, data-processing
// opcodes, ALU command encodings, condition codes and status-flag bit positions.
package id_stage_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] status);
    logic n, z, c, v;
    n = status[ST_N];
    z = status[ST_Z];
    c = status[ST_C];
    v = status[ST_V];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = ~c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = c & ~z;
      COND_LS: cond_pass = ~c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID/EX bundle: everything the decode stage hands to execute, driven from its pipeline register.
interface id_stage_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] pc_out;
  logic              wb_en;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              b;
  logic              s;
  logic [3:0]        exe_cmd;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  logic              imm;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm_24;
  logic [3:0]        dest;

  modport master (
    output pc_out, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd,
           val_rn, val_rm, imm, shift_operand, signed_imm_24, dest
  );

  modport slave (
    input pc_out, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd,
          val_rn, val_rm, imm, shift_operand, signed_imm_24, dest
  );
endinterface

// File: rtl/id_stage_register_file.sv
// Architectural register file R0..R(NREGS-1): two combinational read ports with same-cycle
// writeback bypass, one synchronous write port. Index NREGS and above reads as zero.
module id_stage_register_file #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        rd_idx1,
  input  logic [3:0]        rd_idx2,
  output logic [DATA_W-1:0] rd_val1,
  output logic [DATA_W-1:0] rd_val2,
  input  logic              wr_en,
  input  logic [3:0]        wr_idx,
  input  logic [DATA_W-1:0] wr_val
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // A read of the register being written this cycle sees the new value, not the stale one.
  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] idx);
    if (int'(idx) >= NREGS)
      read_port = '0;
    else if (wr_en && (wr_idx == idx))
      read_port = wr_val;
    else
      read_port = regs_q[idx];
  endfunction

  always_comb begin
    rd_val1 = read_port(rd_idx1);
    rd_val2 = read_port(rd_idx2);
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (int'(wr_idx) < NREGS))
      regs_d[wr_idx] = wr_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: decodes the IF/ID instruction, evaluates its condition against the
// status flags, reads operands, and captures everything in the ID/EX register.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [31:0]       instruction_in,
  input  logic [3:0]        status_in,
  input  logic              hazard,
  input  logic              flush,
  input  logic              wb_en_in,
  input  logic [3:0]        wb_dest_in,
  input  logic [DATA_W-1:0] wb_value_in,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              two_src,
  id_stage_if.master        ex
);

  logic [3:0]  cond;
  logic [1:0]  mode;
  logic [3:0]  opcode;
  logic        s_bit;
  logic        imm_bit;
  logic [3:0]  rn_idx;
  logic [3:0]  rd_idx;
  logic [3:0]  rm_idx;

  ctrl_t       ctrl_dec;
  ctrl_t       ctrl_cond;
  logic        cond_ok;
  logic        is_store;

  logic [DATA_W-1:0] rf_val1;
  logic [DATA_W-1:0] rf_val2;

  ctrl_t             ctrl_d,   ctrl_q;
  logic [DATA_W-1:0] pc_d,     pc_q;
  logic [DATA_W-1:0] val_rn_d, val_rn_q;
  logic [DATA_W-1:0] val_rm_d, val_rm_q;
  logic              imm_d,    imm_q;
  logic [11:0]       shift_d,  shift_q;
  logic [23:0]       simm_d,   simm_q;
  logic [3:0]        dest_d,   dest_q;

  always_comb begin
    cond    = instruction_in[31:28];
    mode    = instruction_in[27:26];
    imm_bit = instruction_in[25];
    opcode  = instruction_in[24:21];
    s_bit   = instruction_in[20];
    rn_idx  = instruction_in[19:16];
    rd_idx  = instruction_in[15:12];
    rm_idx  = instruction_in[3:0];
  end

  always_comb begin
    ctrl_dec = '0;
    case (mode)
      MODE_DP: begin
        ctrl_dec.wb_en = 1'b1;
        ctrl_dec.s     = s_bit;
        case (opcode)
          OP_MOV: ctrl_dec.exe_cmd = EXE_MOV;
          OP_MVN: ctrl_dec.exe_cmd = EXE_MVN;
          OP_ADD: ctrl_dec.exe_cmd = EXE_ADD;
          OP_ADC: ctrl_dec.exe_cmd = EXE_ADC;
          OP_SUB: ctrl_dec.exe_cmd = EXE_SUB;
          OP_SBC: ctrl_dec.exe_cmd = EXE_SBC;
          OP_AND: ctrl_dec.exe_cmd = EXE_AND;
          OP_ORR: ctrl_dec.exe_cmd = EXE_ORR;
          OP_EOR: ctrl_dec.exe_cmd = EXE_EOR;
          OP_CMP: begin
            ctrl_dec.exe_cmd = EXE_SUB;
            ctrl_dec.wb_en   = 1'b0;
          end
          OP_TST: begin
            ctrl_dec.exe_cmd = EXE_AND;
            ctrl_dec.wb_en   = 1'b0;
          end
          default: ctrl_dec = '0;
        endcase
      end
      MODE_MEM: begin
        ctrl_dec.exe_cmd  = EXE_ADD;
        ctrl_dec.mem_r_en = s_bit;
        ctrl_dec.wb_en    = s_bit;
        ctrl_dec.mem_w_en = ~s_bit;
      end
      MODE_BR: ctrl_dec.b = 1'b1;
      default: ctrl_dec = '0;
    endcase
  end

  // A failed condition kills side effects but keeps the ALU command and data fields.
  always_comb begin
    cond_ok   = cond_pass(cond, status_in);
    ctrl_cond = ctrl_dec;
    if (!cond_ok) begin
      ctrl_cond.wb_en    = 1'b0;
      ctrl_cond.mem_r_en = 1'b0;
      ctrl_cond.mem_w_en = 1'b0;
      ctrl_cond.b        = 1'b0;
      ctrl_cond.s        = 1'b0;
    end
  end

  // STR needs Rd as its store data, so the second read port follows src2.
  always_comb begin
    is_store = ctrl_dec.mem_w_en;
    src1     = rn_idx;
    src2     = is_store ? rd_idx : rm_idx;
    two_src  = ~imm_bit | is_store;
  end

  id_stage_register_file #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_register_file (
    .clk     (clk),
    .rst     (rst),
    .rd_idx1 (src1),
    .rd_idx2 (src2),
    .rd_val1 (rf_val1),
    .rd_val2 (rf_val2),
    .wr_en   (wb_en_in),
    .wr_idx  (wb_dest_in),
    .wr_val  (wb_value_in)
  );

  always_comb begin
    ctrl_d   = ctrl_cond;
    pc_d     = pc_in;
    val_rn_d = rf_val1;
    val_rm_d = rf_val2;
    imm_d    = imm_bit;
    shift_d  = instruction_in[11:0];
    simm_d   = instruction_in[23:0];
    dest_d   = rd_idx;
    if (hazard || flush) begin
      ctrl_d   = '0;
      pc_d     = '0;
      val_rn_d = '0;
      val_rm_d = '0;
      imm_d    = 1'b0;
      shift_d  = '0;
      simm_d   = '0;
      dest_d   = '0;
    end
  end

  // ID/EX pipeline register boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      pc_q     <= '0;
      val_rn_q <= '0;
      val_rm_q <= '0;
      imm_q    <= 1'b0;
      shift_q  <= '0;
      simm_q   <= '0;
      dest_q   <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      pc_q     <= pc_d;
      val_rn_q <= val_rn_d;
      val_rm_q <= val_rm_d;
      imm_q    <= imm_d;
      shift_q  <= shift_d;
      simm_q   <= simm_d;
      dest_q   <= dest_d;
    end
  end

  always_comb begin
    ex.pc_out        = pc_q;
    ex.wb_en         = ctrl_q.wb_en;
    ex.mem_r_en      = ctrl_q.mem_r_en;
    ex.mem_w_en      = ctrl_q.mem_w_en;
    ex.b             = ctrl_q.b;
    ex.s             = ctrl_q.s;
    ex.exe_cmd       = ctrl_q.exe_cmd;
    ex.val_rn        = val_rn_q;
    ex.val_rm        = val_rm_q;
    ex.imm           = imm_q;
    ex.shift_operand = shift_q;
    ex.signed_imm_24 = simm_q;
    ex.dest          = dest_q;
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios then randomized instructions, writebacks, bubbles and
// resets, all checked against a behavioural model of the decode rules and register file.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;
  logic [3:0]  status_in;
  logic        hazard;
  logic        flush;
  logic        wb_en_in;
  logic [3:0]  wb_dest_in;
  logic [31:0] wb_value_in;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;

  always #5 clk = ~clk;

  id_stage_if #(.DATA_W(32)) ex ();

  id_stage #(.DATA_W(32), .NREGS(15)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .instruction_in (instruction_in),
    .status_in      (status_in),
    .hazard         (hazard),
    .flush          (flush),
    .wb_en_in       (wb_en_in),
    .wb_dest_in     (wb_dest_in),
    .wb_value_in    (wb_value_in),
    .src1           (src1),
    .src2           (src2),
    .two_src        (two_src),
    .ex             (ex)
  );

  typedef struct {
    logic [31:0] pc;
    logic        wb_en, mem_r_en, mem_w_en, b, s;
    logic [3:0]  exe_cmd;
    logic [31:0] rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] simm;
    logic [3:0]  dest;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] ref_regs [15];
  logic [3:0]  alu_of [logic [3:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] st);
    bit n, z, cy, v;
    n = st[3]; z = st[2]; cy = st[1]; v = st[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] read_ref(input logic [3:0] idx, input bit we,
                                           input logic [3:0] wd, input logic [31:0] wv);
    if (idx == 4'd15) return 32'h0;
    if (we && wd == idx) return wv;
    return ref_regs[idx];
  endfunction

  task automatic step(input logic [31:0] ins, input logic [3:0] st, input bit hz, input bit fl,
                      input bit we, input logic [3:0] wd, input logic [31:0] wv,
                      input bit r, input logic [31:0] pc);
    exp_t        e;
    logic [1:0]  mode;
    logic [3:0]  op;
    bit          str;
    logic [3:0]  rm_sel;
    rst = r; instruction_in = ins; status_in = st; hazard = hz; flush = fl;
    wb_en_in = we; wb_dest_in = wd; wb_value_in = wv; pc_in = pc;
    mode   = ins[27:26];
    op     = ins[24:21];
    str    = (mode == 2'b01) && !ins[20];
    rm_sel = str ? ins[15:12] : ins[3:0];
    #1;
    check("src1", 32'(src1), 32'(ins[19:16]));
    check("src2", 32'(src2), 32'(rm_sel));
    check("two_src", 32'(two_src), 32'(!ins[25] || str));
    e = '{default: '0};
    if (!(r || hz || fl)) begin
      e.pc   = pc;
      e.imm  = ins[25];
      e.sh   = ins[11:0];
      e.simm = ins[23:0];
      e.dest = ins[15:12];
      e.rn   = read_ref(ins[19:16], we, wd, wv);
      e.rm   = read_ref(rm_sel, we, wd, wv);
      if (mode == 2'b00 && alu_of.exists(op)) begin
        e.exe_cmd = alu_of[op];
        e.wb_en   = !(op == 4'b1010 || op == 4'b1000);
        e.s       = ins[20];
      end else if (mode == 2'b01) begin
        e.exe_cmd  = 4'b0010;
        e.mem_r_en = ins[20];
        e.wb_en    = ins[20];
        e.mem_w_en = !ins[20];
      end else if (mode == 2'b10) begin
        e.b = 1'b1;
      end
      if (!cond_holds(ins[31:28], st)) begin
        e.wb_en = 0; e.mem_r_en = 0; e.mem_w_en = 0; e.b = 0; e.s = 0;
      end
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 15; i++) ref_regs[i] = 32'h0;
    end else if (we && wd != 4'd15) begin
      ref_regs[wd] = wv;
    end
    #1;
    check("pc_out", ex.pc_out, e.pc);
    check("ctrl{wb,mr,mw,b,s}", 32'({ex.wb_en, ex.mem_r_en, ex.mem_w_en, ex.b, ex.s}),
          32'({e.wb_en, e.mem_r_en, e.mem_w_en, e.b, e.s}));
    check("exe_cmd", 32'(ex.exe_cmd), 32'(e.exe_cmd));
    check("val_rn", ex.val_rn, e.rn);
    check("val_rm", ex.val_rm, e.rm);
    check("imm", 32'(ex.imm), 32'(e.imm));
    check("shift_operand", 32'(ex.shift_operand), 32'(e.sh));
    check("signed_imm_24", 32'(ex.signed_imm_24), 32'(e.simm));
    check("dest", 32'(ex.dest), 32'(e.dest));
  endtask

  initial begin
    logic [31:0] ins;
    logic [3:0]  wd;
    alu_of[4'b1101] = 4'b0001; alu_of[4'b1111] = 4'b1001;
    alu_of[4'b0100] = 4'b0010; alu_of[4'b0101] = 4'b0011;
    alu_of[4'b0010] = 4'b0100; alu_of[4'b0110] = 4'b0101;
    alu_of[4'b0000] = 4'b0110; alu_of[4'b1100] = 4'b0111;
    alu_of[4'b0001] = 4'b1000; alu_of[4'b1010] = 4'b0100;
    alu_of[4'b1000] = 4'b0110;
    for (int i = 0; i < 15; i++) ref_regs[i] = 32'h0;

    // Reset for two cycles with busy inputs; everything must come out zero.
    step(32'hE0834003, 4'hF, 0, 0, 1, 4'd3, 32'h1234_5678, 1, 32'h10);
    step(32'hE3A00014, 4'hF, 0, 0, 1, 4'd5, 32'h8765_4321, 1, 32'h11);
    check("reset_wb_en", 32'(ex.wb_en), 32'h0);

    for (int i = 0; i < 15; i++)
      step(32'hE0800000 | (i << 16) | i, 4'h0, 0, 0, 0, 4'd0, 32'h0, 0, 32'(i));

    // MOV R0,#20
    step(32'hE3A00014, 4'h0, 0, 0, 0, 4'd0, 32'h0, 0, 32'h100);
    check("mov_exe_cmd", 32'(ex.exe_cmd), 32'h1);
    check("mov_wb_en", 32'(ex.wb_en), 32'h1);
    check("mov_imm", 32'(ex.imm), 32'h1);
    check("mov_shift", 32'(ex.shift_operand), 32'h014);

    // ADD R4,R3,R3 while R3 is being written: bypass on both ports.
    step(32'hE0834003, 4'h0, 0, 0, 1, 4'd3, 32'hDEADBEEF, 0, 32'h101);
    check("add_val_rn", ex.val_rn, 32'hDEADBEEF);
    check("add_val_rm", ex.val_rm, 32'hDEADBEEF);
    check("add_exe_cmd", 32'(ex.exe_cmd), 32'h2);
    step(32'hE0835003, 4'h0, 0, 0, 0, 4'd0, 32'h0, 0, 32'h102);
    check("r3_from_array", ex.val_rn, 32'hDEADBEEF);

    // MOVNE: Z=1 kills control, Z=0 lets it through.
    step(32'h13A00014, 4'b0100, 0, 0, 0, 4'd0, 32'h0, 0, 32'h103);
    check("ne_fail_wb_en", 32'(ex.wb_en), 32'h0);
    step(32'h13A00014, 4'b0000, 0, 0, 0, 4'd0, 32'h0, 0, 32'h104);
    check("ne_pass_wb_en", 32'(ex.wb_en), 32'h1);

    // STR R1,[R4], then the same with flush.
    step(32'hE5841000, 4'h0, 0, 0, 0, 4'd0, 32'h0, 0, 32'h105);
    check("str_mem_w_en", 32'(ex.mem_w_en), 32'h1);
    step(32'hE5841000, 4'h0, 0, 1, 0, 4'd0, 32'h0, 0, 32'h106);
    check("str_flush_mem_w_en", 32'(ex.mem_w_en), 32'h0);
    step(32'hE5841000, 4'h0, 1, 1, 0, 4'd0, 32'h0, 0, 32'h107);

    // BLT: N!=V takes it, N==V does not.
    step(32'hBAFFFFF7, 4'b1000, 0, 0, 0, 4'd0, 32'h0, 0, 32'h108);
    check("blt_b", 32'(ex.b), 32'h1);
    check("blt_simm", 32'(ex.signed_imm_24), 32'hFFFFF7);
    step(32'hBAFFFFF7, 4'b1001, 0, 0, 0, 4'd0, 32'h0, 0, 32'h109);
    check("blt_nv_equal_b", 32'(ex.b), 32'h0);

    // Writes to index 15 are dropped and reads of 15 are zero, even during the write.
    step(32'hE08F000F, 4'h0, 0, 0, 1, 4'd15, 32'hCAFE_F00D, 0, 32'h10A);

    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(1, 0) == 0) ins[31:28] = 4'hE;
      wd = 4'($urandom_range(15, 0));
      if ($urandom_range(3, 0) == 0) wd = ins[19:16];
      step(ins, 4'($urandom_range(15, 0)), ($urandom_range(9, 0) == 0),
           ($urandom_range(9, 0) == 0), ($urandom_range(1, 0) == 1), wd, $urandom,
           ($urandom_range(49, 0) == 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage ARM-subset pipeline. It sits directly downstream of the fetch stage and its IF/ID register, and directly upstream of execute. It decodes the fetched 32-bit instruction, checks its condition field against the status flags, and reads operands from an internal 15-entry register file that the writeback stage writes. All decoded fields are captured in an internal ID/EX pipeline register, so every output except the hazard-facing source fields is registered.

## Interface
Parameters:
- DATA_W, 32, datapath and register width
- NREGS, 15, architectural registers R0–R14

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- pc_in  in  32  PC+1 from IF/ID register
- instruction_in  in  32  instruction from IF/ID register
- status_in  in  4  {N,Z,C,V} from status register
- hazard  in  1  from hazard unit: load a bubble into ID/EX
- flush  in  1  branch taken in EX: load a bubble into ID/EX
- wb_en_in  in  1  writeback enable
- wb_dest_in  in  4  writeback register index
- wb_value_in  in  32  writeback data
- src1  out  4  combinational Rn [19:16], for the hazard unit
- src2  out  4  combinational: Rd [15:12] if STR, else Rm [3:0]
- two_src  out  1  combinational: ~I | mem_w_en_decoded
- pc_out  out  32  registered pc_in
- wb_en, mem_r_en, mem_w_en, b, s  out  1 each  registered control
- exe_cmd  out  4  registered ALU command
- val_rn, val_rm  out  32 each  registered operands
- imm  out  1  registered I bit [25]
- shift_operand  out  12  registered [11:0]
- signed_imm_24  out  24  registered [23:0]
- dest  out  4  registered Rd [15:12]

## Operation
- Mode [27:26]: 00 = data processing, 01 = memory, 10 = branch. 11 decodes as NOP with all control 0.
- Data-processing opcode [24:21] maps to exe_cmd as follows:
  - MOV 1101→0001, MVN 1111→1001
  - ADD 0100→0010, ADC 0101→0011
  - SUB 0010→0100, SBC 0110→0101
  - AND 0000→0110, ORR 1100→0111, EOR 0001→1000
  - CMP 1010→0100, TST 1000→0110
  - All other opcodes decode as NOP.
- wb_en = 1 for all data-processing opcodes except CMP and TST. s = S bit [20] for data processing.
- Memory: S=1 is LDR (mem_r_en=1, wb_en=1); S=0 is STR (mem_w_en=1). exe_cmd is 0010 for both; s is 0.
- Branch: b=1, exe_cmd is don't-care (drive 0000), no wb.
- Condition [31:28]:
  - EQ Z, NE ~Z
  - CS C, CC ~C
  - MI N, PL ~N
  - VS V, VC ~V
  - HI C&~Z, LS ~C|Z
  - GE N==V, LT N!=V
  - GT ~Z&(N==V), LE Z|(N!=V)
  - AL 1110 is always true; 1111 is false.
  - If the condition fails, wb_en, mem_r_en, mem_w_en, b and s are forced to 0. Data fields are still captured.
- Register file:
  - Write on the rising edge when wb_en_in=1 and wb_dest_in<15.
  - Writes to index 15 are ignored. Reads of index 15 return 0.
  - Internal bypass: if wb_en_in=1 and wb_dest_in equals a read index, that read returns wb_value_in in the same cycle.
- Bubble: when hazard or flush is 1, every ID/EX output is loaded with 0. Flush and hazard together also give a bubble.

## Timing
- Latency is one cycle: decode of instruction_in in cycle N appears on the registered outputs after edge N+1.
- src1, src2 and two_src are combinational from instruction_in with zero latency. They are unaffected by hazard and flush.
- Reset: on any rising edge with rst=1, all registered outputs and all register-file entries become 0. rst overrides hazard, flush and writeback on that edge, including mid-operation.
- A writeback in cycle N is visible to a read in cycle N via the bypass, and from the register array in cycle N+1 onward.
- The stage has no stall of its own. Upstream freezing is the IF/ID register's job; this block only inserts bubbles.

## Structure
- Shared package holds:
  - mode constants
  - opcode constants
  - exe_cmd encodings
  - condition-code constants
  - status bit indices (N=3, Z=2, C=1, V=0)
- Sub-module register_file: 15×32 array, two combinational read ports with write bypass, one synchronous write port, synchronous reset.
- Condition check and decode are combinational logic in id_stage, followed by the ID/EX register.

## Test plan
- Reset with rst=1 for 2 cycles → all outputs 0. Reading R0–R14 returns 0.
- Instruction E3A00014 (MOV R0,#20) with AL → exe_cmd=0001, wb_en=1, imm=1, dest=0, shift_operand=014.
- Write R3=0xDEADBEEF via wb, then ADD R4,R3,R3 in the same cycle → val_rn=val_rm=0xDEADBEEF via bypass, exe_cmd=0010.
- Instruction 0x1... (NE) with status Z=1 → all control 0. With Z=0 → control active.
- Instruction E5841000 (STR R1,[R4]) → mem_w_en=1, src2=1, two_src=1. Same cycle with flush=1 → all registered outputs 0.
- Instruction BAFFFFF7 (BLT) with N=1, V=0 → b=1, signed_imm_24=FFFFF7. With N=V → b=0.
